// File: rtl/io_input_debounce_if.sv
// Bus bundle between the raw board inputs and the debounced input-port words.
// The bench/board side is the master; the debouncer is the slave.
interface io_input_debounce_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] raw_port0;
  logic [DATA_W-1:0] raw_port1;
  logic [DATA_W-1:0] in_port0;
  logic [DATA_W-1:0] in_port1;
  logic              chg0;
  logic              chg1;

  modport master (
    output raw_port0, raw_port1,
    input  in_port0, in_port1, chg0, chg1
  );

  modport slave (
    input  raw_port0, raw_port1,
    output in_port0, in_port1, chg0, chg1
  );
endinterface

// File: rtl/io_input_debounce.sv
// Two independent channels: two-flop synchroniser, then a word-level debounce FSM that
// commits a new word only after it has held unchanged for DB_CYCLES consecutive cycles.
module io_input_debounce #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1),
  parameter int DATA_W    = 32
) (
  input  logic               io_clk,
  input  logic               reset,
  io_input_debounce_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SETTLE = 1'b1;

  logic [DATA_W-1:0] raw      [2];
  logic [DATA_W-1:0] s1_q     [2];
  logic [DATA_W-1:0] s1_d     [2];
  logic [DATA_W-1:0] s2_q     [2];
  logic [DATA_W-1:0] s2_d     [2];
  logic [DATA_W-1:0] stable_q [2];
  logic [DATA_W-1:0] stable_d [2];
  logic [DATA_W-1:0] cand_q   [2];
  logic [DATA_W-1:0] cand_d   [2];
  logic [CNT_W-1:0]  cnt_q    [2];
  logic [CNT_W-1:0]  cnt_d    [2];
  logic [0:0]        state_q  [2];
  logic [0:0]        state_d  [2];
  logic              chg_q    [2];
  logic              chg_d    [2];

  assign raw[0] = bus.raw_port0;
  assign raw[1] = bus.raw_port1;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      // Synchroniser stages: the FSM below never looks at anything but s2.
      s1_d[i]     = raw[i];
      s2_d[i]     = s1_q[i];

      // Debounce stage.
      stable_d[i] = stable_q[i];
      cand_d[i]   = cand_q[i];
      cnt_d[i]    = cnt_q[i];
      state_d[i]  = state_q[i];
      chg_d[i]    = 1'b0;

      if (state_q[i] == IDLE) begin
        if (s2_q[i] != stable_q[i]) begin
          cand_d[i]  = s2_q[i];
          cnt_d[i]   = CNT_W'(1);
          state_d[i] = SETTLE;
        end else begin
          cnt_d[i]   = '0;
        end
      end else begin
        if (s2_q[i] == stable_q[i]) begin
          state_d[i]  = IDLE;
          cnt_d[i]    = '0;
        end else if (s2_q[i] != cand_q[i]) begin
          cand_d[i]   = s2_q[i];
          cnt_d[i]    = CNT_W'(1);
        end else if (cnt_q[i] == CNT_W'(DB_CYCLES)) begin
          stable_d[i] = cand_q[i];
          chg_d[i]    = 1'b1;
          cnt_d[i]    = '0;
          state_d[i]  = IDLE;
        end else begin
          cnt_d[i]    = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge io_clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        s1_q[i]     <= '0;
        s2_q[i]     <= '0;
        stable_q[i] <= '0;
        cand_q[i]   <= '0;
        cnt_q[i]    <= '0;
        state_q[i]  <= IDLE;
        chg_q[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        s1_q[i]     <= s1_d[i];
        s2_q[i]     <= s2_d[i];
        stable_q[i] <= stable_d[i];
        cand_q[i]   <= cand_d[i];
        cnt_q[i]    <= cnt_d[i];
        state_q[i]  <= state_d[i];
        chg_q[i]    <= chg_d[i];
      end
    end
  end

  assign bus.in_port0 = stable_q[0];
  assign bus.in_port1 = stable_q[1];
  assign bus.chg0     = chg_q[0];
  assign bus.chg1     = chg_q[1];

endmodule

// File: tb/tb_io_input_debounce.sv
// Bench for io_input_debounce: a DB_CYCLES=16 and a DB_CYCLES=1 instance share the same
// raw inputs and reset, and both are tracked by a run-length reference model.
module tb_io_input_debounce;

  logic        io_clk;
  logic        reset;
  logic [31:0] raw0;
  logic [31:0] raw1;
  int          total_cnt = 0;
  int          pass_cnt  = 0;

  io_input_debounce_if #(.DATA_W(32)) if16 ();
  io_input_debounce_if #(.DATA_W(32)) if1 ();

  assign if16.raw_port0 = raw0;
  assign if16.raw_port1 = raw1;
  assign if1.raw_port0  = raw0;
  assign if1.raw_port1  = raw1;

  io_input_debounce #(.DB_CYCLES(16)) dut16 (.io_clk(io_clk), .reset(reset), .bus(if16));
  io_input_debounce #(.DB_CYCLES(1))  dut1  (.io_clk(io_clk), .reset(reset), .bus(if1));

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  // Reference model: a word is committed once the synchronised value has been seen at
  // DB+1 consecutive edges while differing from the committed word. Index [dut][channel].
  logic [31:0] m_s1     [2][2];
  logic [31:0] m_s2     [2][2];
  logic [31:0] m_prev   [2][2];
  logic [31:0] m_stable [2][2];
  int          m_run    [2][2];
  logic        m_chg    [2][2];

  function automatic int db_of(int d);
    return (d == 0) ? 16 : 1;
  endfunction

  function automatic int next_run(int d, int c);
    return (m_s2[d][c] == m_prev[d][c]) ? m_run[d][c] + 1 : 1;
  endfunction

  always @(posedge io_clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (reset) begin
          m_s1[d][c]     <= 32'h0;
          m_s2[d][c]     <= 32'h0;
          m_prev[d][c]   <= 32'h0;
          m_stable[d][c] <= 32'h0;
          m_run[d][c]    <= 0;
          m_chg[d][c]    <= 1'b0;
        end else begin
          m_s1[d][c]   <= (c == 0) ? raw0 : raw1;
          m_s2[d][c]   <= m_s1[d][c];
          m_prev[d][c] <= m_s2[d][c];
          m_run[d][c]  <= next_run(d, c);
          if (m_s2[d][c] != m_stable[d][c] && next_run(d, c) == db_of(d) + 1) begin
            m_stable[d][c] <= m_s2[d][c];
            m_chg[d][c]    <= 1'b1;
          end else begin
            m_chg[d][c]    <= 1'b0;
          end
        end
      end
    end
  end

  logic [131:0] dut_obs;
  logic [131:0] mdl_obs;
  assign dut_obs = {if16.in_port0, if16.in_port1, if16.chg0, if16.chg1,
                    if1.in_port0, if1.in_port1, if1.chg0, if1.chg1};
  assign mdl_obs = {m_stable[0][0], m_stable[0][1], m_chg[0][0], m_chg[0][1],
                    m_stable[1][0], m_stable[1][1], m_chg[1][0], m_chg[1][1]};

  function automatic logic [31:0] pick_word();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'h0000_000A;
      2:       return 32'h0000_000B;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    raw0  = 32'h1234_5678;
    raw1  = 32'h0;
    repeat (3) @(negedge io_clk);
    total_cnt++;
    if (dut_obs !== 132'h0)
      $display("FAIL reset_state: got %h want 0", dut_obs);
    else pass_cnt++;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge io_clk); @(negedge io_clk);
      total_cnt++;
      if (dut_obs !== mdl_obs)
        $display("FAIL reset_model edge %0d: got %h want %h", k, dut_obs, mdl_obs);
      else pass_cnt++;
      total_cnt++;
      if (if16.in_port0 !== ((k >= 18) ? 32'h1234_5678 : 32'h0) || if16.chg0 !== 1'(k == 18))
        $display("FAIL reset_commit16 edge %0d: got %h/%b", k, if16.in_port0, if16.chg0);
      else pass_cnt++;
      total_cnt++;
      if (if16.in_port1 !== 32'h0 || if16.chg1 !== 1'b0)
        $display("FAIL reset_port1_idle edge %0d: got %h/%b want 0/0", k, if16.in_port1, if16.chg1);
      else pass_cnt++;
      if (k == 3) begin
        total_cnt++;
        if (if1.in_port0 !== 32'h1234_5678 || if1.chg0 !== 1'b1)
          $display("FAIL reset_commit1 edge 3: got %h/%b want 12345678/1", if1.in_port0, if1.chg0);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_glitch();
    int bad = 0;
    for (int k = 0; k < 35; k++) begin
      raw1 = (k < 5) ? 32'hFFFF_FFFF : 32'h0;
      @(posedge io_clk); @(negedge io_clk);
      total_cnt++;
      if (dut_obs !== mdl_obs)
        $display("FAIL glitch_model cycle %0d: got %h want %h", k, dut_obs, mdl_obs);
      else pass_cnt++;
      if (if16.in_port1 !== 32'h0 || if16.chg1 !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0)
      $display("FAIL glitch_reject: %0d cycles with port1 disturbed, want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_bounce_restart();
    int pulses   = 0;
    int commit_k = -1;
    raw0 = 32'h0;
    for (int k = 0; k < 25; k++) begin
      @(posedge io_clk); @(negedge io_clk);
      total_cnt++;
      if (dut_obs !== mdl_obs)
        $display("FAIL bounce_pre_model cycle %0d: got %h want %h", k, dut_obs, mdl_obs);
      else pass_cnt++;
    end
    for (int k = 0; k < 40; k++) begin
      raw0 = (k >= 3 && k < 6) ? 32'h0000_000B : 32'h0000_000A;
      @(posedge io_clk); @(negedge io_clk);
      total_cnt++;
      if (dut_obs !== mdl_obs)
        $display("FAIL bounce_model cycle %0d: got %h want %h", k, dut_obs, mdl_obs);
      else pass_cnt++;
      if (if16.chg0 === 1'b1) begin
        pulses++;
        commit_k = k;
      end
    end
    total_cnt++;
    if (pulses !== 1 || commit_k !== 24 || if16.in_port0 !== 32'h0000_000A)
      $display("FAIL bounce_restart: pulses %0d at %0d value %h, want 1 at 24 value a",
               pulses, commit_k, if16.in_port0);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int p0 = 0, p1 = 0, k0 = -1, k1 = -1;
    raw0 = 32'h0000_00C0;
    raw1 = 32'h0000_00C4;
    for (int k = 0; k < 25; k++) begin
      @(posedge io_clk); @(negedge io_clk);
      total_cnt++;
      if (dut_obs !== mdl_obs)
        $display("FAIL simul_model cycle %0d: got %h want %h", k, dut_obs, mdl_obs);
      else pass_cnt++;
      if (if16.chg0 === 1'b1) begin p0++; k0 = k; end
      if (if16.chg1 === 1'b1) begin p1++; k1 = k; end
    end
    total_cnt++;
    if (p0 !== 1 || p1 !== 1 || k0 !== 18 || k1 !== 18)
      $display("FAIL simul_pulses: chg0 %0d@%0d chg1 %0d@%0d, want 1@18 each", p0, k0, p1, k1);
    else pass_cnt++;
    total_cnt++;
    if (if16.in_port0 !== 32'h0000_00C0 || if16.in_port1 !== 32'h0000_00C4)
      $display("FAIL simul_values: got %h %h want c0 c4", if16.in_port0, if16.in_port1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_settle();
    raw0 = 32'h55AA_55AA;
    for (int k = 0; k < 34; k++) begin
      reset = (k == 10 || k == 11);
      @(posedge io_clk); @(negedge io_clk);
      total_cnt++;
      if (dut_obs !== mdl_obs)
        $display("FAIL midrst_model cycle %0d: got %h want %h", k, dut_obs, mdl_obs);
      else pass_cnt++;
      if (k >= 10) begin
        total_cnt++;
        if (if16.in_port0 !== ((k >= 30) ? 32'h55AA_55AA : 32'h0) || if16.chg0 !== 1'(k == 30))
          $display("FAIL midrst_port0 cycle %0d: got %h/%b", k, if16.in_port0, if16.chg0);
        else pass_cnt++;
      end
      if (k == 10) begin
        total_cnt++;
        if (dut_obs !== 132'h0)
          $display("FAIL midrst_cleared: got %h want 0", dut_obs);
        else pass_cnt++;
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_min_filter();
    int rej = 0, pulses = 0, commit_k = -1;
    for (int k = 0; k < 20; k++) begin
      raw0 = (k == 0 || k >= 10) ? 32'h0F0F_0F0F : 32'h55AA_55AA;
      @(posedge io_clk); @(negedge io_clk);
      total_cnt++;
      if (dut_obs !== mdl_obs)
        $display("FAIL minf_model cycle %0d: got %h want %h", k, dut_obs, mdl_obs);
      else pass_cnt++;
      if (k < 10 && (if1.chg0 === 1'b1 || if1.in_port0 !== 32'h55AA_55AA)) rej++;
      if (k >= 10 && if1.chg0 === 1'b1) begin pulses++; commit_k = k; end
    end
    total_cnt++;
    if (rej !== 0)
      $display("FAIL minf_pulse_reject: %0d disturbed cycles, want 0", rej);
    else pass_cnt++;
    total_cnt++;
    if (pulses !== 1 || commit_k !== 13 || if1.in_port0 !== 32'h0F0F_0F0F)
      $display("FAIL minf_commit: pulses %0d at %0d value %h, want 1 at 13 value 0f0f0f0f",
               pulses, commit_k, if1.in_port0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int h0 = 0, h1 = 0;
    for (int k = 0; k < 800; k++) begin
      if (h0 == 0) begin raw0 = pick_word(); h0 = $urandom_range(1, 24); end
      if (h1 == 0) begin raw1 = pick_word(); h1 = $urandom_range(1, 24); end
      h0--; h1--;
      reset = ($urandom_range(0, 199) == 0);
      @(posedge io_clk); @(negedge io_clk);
      total_cnt++;
      if (dut_obs !== mdl_obs)
        $display("FAIL random_model cycle %0d: got %h want %h", k, dut_obs, mdl_obs);
      else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce_restart();
    test_simultaneous();
    test_reset_mid_settle();
    test_min_filter();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/io_input_debounce.md
# io_input_debounce

Front-end conditioner for the memory-mapped input ports of the pipeline CPU. It takes two raw, asynchronous 32-bit board inputs (switches/buttons), synchronises them into `io_clk`, and debounces each port word. It drives the filtered words onto `in_port0`/`in_port1`, which feed the input register stage directly. A one-cycle change strobe per port is provided for optional interrupt/poll logic.

## Interface
- `DB_CYCLES`, default 16: consecutive cycles a new synchronised word must stay unchanged before it is committed; legal range 1..65535.
- `CNT_W`, default `$clog2(DB_CYCLES+1)`: settle counter width; derived, not overridden.

- `io_clk`  in  1  system I/O clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `raw_port0`  in  32  asynchronous raw input word, port 0.
- `raw_port1`  in  32  asynchronous raw input word, port 1.
- `in_port0`  out  32  debounced word, port 0 (registered).
- `in_port1`  out  32  debounced word, port 1 (registered).
- `chg0`  out  1  one-cycle pulse when `in_port0` takes a new value.
- `chg1`  out  1  one-cycle pulse when `in_port1` takes a new value.

## Operation
- Two identical, fully independent channels (0, 1). No shared state.
- Per channel: two-flop synchroniser `s1 <= raw`, `s2 <= s1` (whole word). The FSM only looks at `s2`.
- Per channel registers:
  - `stable` (drives `in_port`)
  - `cand` (candidate word)
  - `cnt` (`CNT_W` bits)
  - `state` ∈ {IDLE, SETTLE}
  - `chg`
- IDLE:
  - `s2 == stable`: hold, `cnt` stays 0.
  - `s2 != stable`: `cand <= s2`, `cnt <= 1`, go SETTLE.
- SETTLE, conditions checked in priority order:
  1. `s2 == stable`: glitch. Go IDLE, `cnt <= 0`, `stable` unchanged, no pulse.
  2. `s2 != cand`: still bouncing. `cand <= s2`, `cnt <= 1`, stay SETTLE.
  3. `cnt == DB_CYCLES`: commit. `stable <= cand`, `chg <= 1`, `cnt <= 0`, go IDLE.
  4. Otherwise: `cnt <= cnt + 1`.
- `chg` defaults to 0 every cycle. It is 1 only in the cycle after a commit edge.
- Any bit change counts as a word change. There is no per-bit filtering.
- `cnt` never exceeds `DB_CYCLES`, so no wrap-around is possible.

## Timing
- Reset (synchronous, while `reset` is high at an edge):
  - `s1`, `s2`, `stable`, `cand` ← 0
  - `cnt` ← 0, `state` ← IDLE, `chg` ← 0
  - Hence `in_port0`/`in_port1` = 0 and `chg0`/`chg1` = 0.
- Reset asserted mid-SETTLE discards the candidate. No commit and no pulse occur.
- Latency: let edge 0 be the first edge at which `s1` samples the new raw value, with raw held thereafter.
  - `s2` updates at edge 1.
  - SETTLE is entered at edge 2.
  - Commit happens at edge `DB_CYCLES+2`.
  - With `DB_CYCLES=16`, `in_port` changes and `chg` rises at edge 18; `chg` falls at edge 19.
- `DB_CYCLES=1`: commit occurs at edge 3.
- After reset release with raw ≠ 0 held: commit occurs at edge `DB_CYCLES+2`, counting the first non-reset edge as edge 0.
- Bounce A→B→C during SETTLE: the count restarts from the edge `s2` first shows C.
- Both channels may commit at the same edge. `chg0` and `chg1` are then high together.
- `in_port*` is stable between commits. The downstream register may sample it on any edge.

## Test plan
- Reset then steady input: hold `reset` for 3 cycles with `raw_port0=0x1234_5678`, then release (`DB_CYCLES=16`) → `in_port0=0` through edge 17; `in_port0=0x1234_5678` with `chg0=1` at edge 18; `chg0=0` at edge 19; `in_port1=0` and `chg1=0` throughout.
- Glitch reject: from stable 0, drive `raw_port1=0xFFFF_FFFF` for 5 cycles, then return to 0 → `in_port1` stays 0 and `chg1` is never asserted.
- Bounce restart: `raw_port0` steps 0→0xA→0xB→0xA, changing every 3 cycles, then holds 0xA → commit occurs exactly 18 edges after the last change to 0xA reaches `s1`; a single `chg0` pulse.
- Simultaneous commit: change both raw ports on the same cycle to `0x0000_00C0` and `0x0000_00C4` → both outputs update at the same edge; `chg0` and `chg1` are each high for exactly one cycle together.
- Reset mid-settle: start a change to `0x55AA_55AA`, assert `reset` at edge 10 → outputs read 0 with no pulse; after release, the commit arrives at edge 18, counted from the first non-reset edge.
- Minimum filter: with `DB_CYCLES=1`, a change held for 2 cycles at `s1` commits at edge 3 → single `chg` pulse; a 1-cycle pulse at raw is rejected.
